// File: rtl/dram_controller_multibank.sv
// dram_controller_multibank
//   FPM DRAM controller for a 68000 bus. Drives N banks of 16-bit SIMMs with
//   programmable RAS/CAS/precharge timing and CAS-before-RAS refresh backed by
//   a saturating pending-refresh counter.
//
//   Optional feature macro: DRAM_PAGE_MODE_EN (keeps the row open after an
//   access so a following same-bank/same-row access skips RAS).
//
// Ports
//   CLK_ALT     in   DRAM clock
//   RST         in   synchronous reset, active-low
//   AS, CS      in   CPU address strobe / DRAM chip select, active-low, async
//   LDS, UDS    in   CPU byte strobes, active-low
//   RW          in   1 = read, 0 = write
//   ADDR_IN     in   CPU address bits [23:1]
//   ADDR_OUT    out  muxed row/column address
//   RAS_N       out  per-bank RAS, active-low
//   CASL_N      out  per-bank low-byte CAS, active-low
//   CASU_N      out  per-bank high-byte CAS, active-low
//   WE_N        out  per-bank write enable, active-low
//   DTACK_DRAM  out  data acknowledge, active-low
//   REF_PEND    out  pending refresh count
//
// state | meaning
// IDLE  | waiting for refresh request or access
// ROW   | drive row address
// RAS   | assert RAS on addressed bank
// RCD   | RAS-to-CAS delay
// COL   | drive column address and WE
// CAS   | assert byte CAS strobes
// ACK   | DTACK low until AS released
// PRE   | all strobes high, precharge
// RF1   | CBR: all CAS low
// RF2   | CBR: all RAS low
// RF3   | CBR: all CAS high
// RF4   | CBR: all RAS high
// PAGE  | row held open (page mode build only)
module dram_controller_multibank #(
  parameter int NUM_BANKS   = 2,
  parameter int MUX_W       = 11,
  parameter int REFRESH_CNT = 781,
  parameter int T_RCD       = 1,
  parameter int T_CAS       = 1,
  parameter int T_RP        = 2,
  parameter int MAX_PEND    = 3
) (
  input  logic                 CLK_ALT,
  input  logic                 RST,
  input  logic                 AS,
  input  logic                 LDS,
  input  logic                 UDS,
  input  logic                 RW,
  input  logic                 CS,
  input  logic [23:1]          ADDR_IN,
  output logic [MUX_W-1:0]     ADDR_OUT,
  output logic [NUM_BANKS-1:0] RAS_N,
  output logic [NUM_BANKS-1:0] CASL_N,
  output logic [NUM_BANKS-1:0] CASU_N,
  output logic [NUM_BANKS-1:0] WE_N,
  output logic                 DTACK_DRAM,
  output logic [2:0]           REF_PEND
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int TMR_W  = $clog2(REFRESH_CNT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CNT - 1);
  localparam logic [2:0] PEND_MAX = 3'(MAX_PEND);
  localparam logic [5:0] RCD_LD  = 6'((T_RCD > 0) ? T_RCD - 1 : 0);
  localparam logic [5:0] CAS_LD  = 6'(T_CAS - 1);
  localparam logic [5:0] RP_LD   = 6'(T_RP - 1);
  localparam logic [5:0] PAGE_LD = 6'd63;

  typedef enum logic [3:0] {
    S_IDLE, S_ROW, S_RAS, S_RCD, S_COL, S_CAS, S_ACK, S_PRE,
    S_RF1, S_RF2, S_RF3, S_RF4
`ifdef DRAM_PAGE_MODE_EN
    , S_PAGE
`endif
  } state_t;

  state_t state_q, state_nxt;
  logic [5:0] wait_q, wait_nxt;
  logic [MUX_W-1:0] addr_q, addr_nxt;
  logic [NUM_BANKS-1:0] ras_q, ras_nxt, casl_q, casl_nxt, casu_q, casu_nxt, we_q, we_nxt;
  logic dtack_q, dtack_nxt;
  logic [BANK_W-1:0] bank_q, bank_nxt, bank_sel;
  logic rw_q, rw_nxt, lds_q, lds_nxt, uds_q, uds_nxt;
  logic as_ff1, as_s, cs_ff1, cs_s;
  logic [TMR_W-1:0] ref_tmr_q;
  logic [2:0] ref_pend_q;
  logic ref_tick, ref_start;
  logic [NUM_BANKS-1:0] bank_oh;
  logic [MUX_W-1:0] row_addr, col_addr;
`ifdef DRAM_PAGE_MODE_EN
  logic [MUX_W-1:0] open_row_q, open_row_nxt;
`endif

  assign row_addr = ADDR_IN[MUX_W:1];
  assign col_addr = ADDR_IN[2*MUX_W:MUX_W+1];

  if (NUM_BANKS > 1) begin : g_bank
    assign bank_sel = ADDR_IN[23 -: BANK_W];
  end else begin : g_one_bank
    assign bank_sel = '0;
  end

  always_comb begin
    bank_oh = '0;
    for (int i = 0; i < NUM_BANKS; i++) bank_oh[i] = (bank_q == BANK_W'(i));
  end

  assign ref_tick = (ref_tmr_q == TMR_LAST);

  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_q;
    addr_nxt  = addr_q;
    ras_nxt   = ras_q;
    casl_nxt  = casl_q;
    casu_nxt  = casu_q;
    we_nxt    = we_q;
    dtack_nxt = dtack_q;
    bank_nxt  = bank_q;
    rw_nxt    = rw_q;
    lds_nxt   = lds_q;
    uds_nxt   = uds_q;
    ref_start = 1'b0;
`ifdef DRAM_PAGE_MODE_EN
    open_row_nxt = open_row_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q != 3'd0) begin
          state_nxt = S_RF1;
          ref_start = 1'b1;
        end else if (!cs_s && !as_s) begin
          state_nxt = S_ROW;
          bank_nxt  = bank_sel;
          rw_nxt    = RW;
          lds_nxt   = LDS;
          uds_nxt   = UDS;
        end
      end
      S_ROW: begin
        addr_nxt  = row_addr;
`ifdef DRAM_PAGE_MODE_EN
        open_row_nxt = row_addr;
`endif
        state_nxt = S_RAS;
      end
      S_RAS: begin
        ras_nxt = ras_q & ~bank_oh;
        if (T_RCD == 0) state_nxt = S_COL;
        else begin
          state_nxt = S_RCD;
          wait_nxt  = RCD_LD;
        end
      end
      S_RCD: begin
        if (wait_q == 6'd0) state_nxt = S_COL;
        else wait_nxt = wait_q - 6'd1;
      end
      S_COL: begin
        addr_nxt  = col_addr;
        we_nxt    = rw_q ? (we_q | bank_oh) : (we_q & ~bank_oh);
        state_nxt = S_CAS;
        wait_nxt  = CAS_LD;
      end
      S_CAS: begin
        casl_nxt = lds_q ? (casl_q | bank_oh) : (casl_q & ~bank_oh);
        casu_nxt = uds_q ? (casu_q | bank_oh) : (casu_q & ~bank_oh);
        if (wait_q == 6'd0) state_nxt = S_ACK;
        else wait_nxt = wait_q - 6'd1;
      end
      S_ACK: begin
        dtack_nxt = 1'b0;
        if (as_s) begin
`ifdef DRAM_PAGE_MODE_EN
          state_nxt = S_PAGE;
          casl_nxt  = '1;
          casu_nxt  = '1;
          we_nxt    = '1;
          dtack_nxt = 1'b1;
          wait_nxt  = PAGE_LD;
`else
          state_nxt = S_PRE;
          wait_nxt  = RP_LD;
`endif
        end
      end
      S_PRE: begin
        ras_nxt   = '1;
        casl_nxt  = '1;
        casu_nxt  = '1;
        we_nxt    = '1;
        dtack_nxt = 1'b1;
        addr_nxt  = '0;
        if (wait_q == 6'd0) state_nxt = S_IDLE;
        else wait_nxt = wait_q - 6'd1;
      end
      S_RF1: begin
        casl_nxt  = '0;
        casu_nxt  = '0;
        we_nxt    = '1;
        state_nxt = S_RF2;
      end
      S_RF2: begin
        ras_nxt   = '0;
        state_nxt = S_RF3;
      end
      S_RF3: begin
        casl_nxt  = '1;
        casu_nxt  = '1;
        state_nxt = S_RF4;
      end
      S_RF4: begin
        ras_nxt   = '1;
        state_nxt = S_PRE;
        wait_nxt  = RP_LD;
      end
`ifdef DRAM_PAGE_MODE_EN
      // A hit performs the column phase here, so it lands in CAS next cycle.
      S_PAGE: begin
        if (ref_pend_q != 3'd0 || wait_q == 6'd0) begin
          state_nxt = S_PRE;
          wait_nxt  = RP_LD;
        end else if (!cs_s && !as_s) begin
          if (bank_sel == bank_q && row_addr == open_row_q) begin
            rw_nxt    = RW;
            lds_nxt   = LDS;
            uds_nxt   = UDS;
            addr_nxt  = col_addr;
            we_nxt    = RW ? (we_q | bank_oh) : (we_q & ~bank_oh);
            state_nxt = S_CAS;
            wait_nxt  = CAS_LD;
          end else begin
            state_nxt = S_PRE;
            wait_nxt  = RP_LD;
          end
        end else begin
          wait_nxt = wait_q - 6'd1;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_ALT) begin
    if (!RST) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      ras_q   <= '1;
      casl_q  <= '1;
      casu_q  <= '1;
      we_q    <= '1;
      dtack_q <= 1'b1;
      bank_q  <= '0;
      rw_q    <= 1'b1;
      lds_q   <= 1'b1;
      uds_q   <= 1'b1;
      as_ff1  <= 1'b1;
      as_s    <= 1'b1;
      cs_ff1  <= 1'b1;
      cs_s    <= 1'b1;
`ifdef DRAM_PAGE_MODE_EN
      open_row_q <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      addr_q  <= addr_nxt;
      ras_q   <= ras_nxt;
      casl_q  <= casl_nxt;
      casu_q  <= casu_nxt;
      we_q    <= we_nxt;
      dtack_q <= dtack_nxt;
      bank_q  <= bank_nxt;
      rw_q    <= rw_nxt;
      lds_q   <= lds_nxt;
      uds_q   <= uds_nxt;
      as_ff1  <= AS;
      as_s    <= as_ff1;
      cs_ff1  <= CS;
      cs_s    <= cs_ff1;
`ifdef DRAM_PAGE_MODE_EN
      open_row_q <= open_row_nxt;
`endif
    end
  end

  // A tick coinciding with a refresh start cancels out.
  always_ff @(posedge CLK_ALT) begin
    if (!RST) begin
      ref_tmr_q  <= '0;
      ref_pend_q <= '0;
    end else begin
      ref_tmr_q <= ref_tick ? '0 : ref_tmr_q + TMR_W'(1);
      if (ref_tick && !ref_start) begin
        if (ref_pend_q != PEND_MAX) ref_pend_q <= ref_pend_q + 3'd1;
      end else if (ref_start && !ref_tick) begin
        ref_pend_q <= ref_pend_q - 3'd1;
      end
    end
  end

  assign ADDR_OUT   = addr_q;
  assign RAS_N      = ras_q;
  assign CASL_N     = casl_q;
  assign CASU_N     = casu_q;
  assign WE_N       = we_q;
  assign DTACK_DRAM = dtack_q;
  assign REF_PEND   = ref_pend_q;

endmodule
